// File: rtl/saturn_bus_sequencer.sv
// Bus sequencer: turns two requesters' memory transactions into {is_cmd, nibble} program
// entries for the bus controller's program RAM ring and returns read nibbles.
module saturn_bus_sequencer #(
  parameter logic [3:0] CMD_LOAD_DP  = 4'h7,
  parameter logic [3:0] CMD_DP_READ  = 4'h3,
  parameter logic [3:0] CMD_DP_WRITE = 4'h5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_write,
  input  logic [39:0] i_addr,
  input  logic [7:0]  i_count,
  input  logic [7:0]  i_wdata,
  output logic [1:0]  o_grant,
  output logic [1:0]  o_wdata_pop,
  output logic [3:0]  o_rdata,
  output logic [1:0]  o_rdata_valid,
  output logic [1:0]  o_done,
  output logic        o_prog_we,
  output logic [4:0]  o_prog_waddr,
  output logic [4:0]  o_prog_wdata,
  output logic [4:0]  o_prog_addr,
  input  logic [4:0]  i_bus_prog_addr,
  input  logic        i_bus_read_valid,
  input  logic [3:0]  i_bus_nibble_in,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    StIdle, StLdCmd, StAddr, StOpCmd, StWdata, StRwait, StRdata, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        write_q, write_d;
  logic [19:0] addr_q, addr_d;
  logic [3:0]  count_q, count_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  remaining_q, remaining_d;
  logic [4:0]  prog_addr_q, prog_addr_d;
  logic [3:0]  rdata_q, rdata_d;
  logic [1:0]  rdata_valid_q, rdata_valid_d;

  logic       sel;
  logic       full;
  logic       emit;
  logic       done;
  logic [1:0] pop;
  logic [4:0] entry;
  logic [3:0] wnib;
  logic       adv;

  assign adv  = i_clk_en & ~i_reset;
  // One slot is kept empty so that equal pointers always mean "drained".
  assign full = (prog_addr_q + 5'd1) == i_bus_prog_addr;
  assign wnib = grant_q[1] ? i_wdata[7:4] : i_wdata[3:0];

  always_comb begin
    sel = 1'b0;
    if (i_req == 2'b10)      sel = 1'b1;
    else if (i_req == 2'b11) sel = ~last_grant_q;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    write_d       = write_q;
    addr_d        = addr_q;
    count_d       = count_q;
    idx_d         = idx_q;
    remaining_d   = remaining_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 2'b00;
    emit          = 1'b0;
    done          = 1'b0;
    pop           = 2'b00;
    entry         = 5'h00;
    unique case (state_q)
      StIdle: begin
        if (|i_req) begin
          grant_d      = sel ? 2'b10 : 2'b01;
          last_grant_d = sel;
          write_d      = i_write[sel];
          addr_d       = sel ? i_addr[39:20] : i_addr[19:0];
          count_d      = sel ? i_count[7:4] : i_count[3:0];
          state_d      = StLdCmd;
        end
      end
      StLdCmd: begin
        entry = {1'b1, CMD_LOAD_DP};
        if (!full) begin
          emit    = 1'b1;
          idx_d   = 3'd0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        entry = {1'b0, addr_q[{idx_q, 2'b00} +: 4]};
        if (!full) begin
          emit = 1'b1;
          if (idx_q == 3'd4) state_d = StOpCmd;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      StOpCmd: begin
        entry = {1'b1, write_q ? CMD_DP_WRITE : CMD_DP_READ};
        if (!full) begin
          emit        = 1'b1;
          remaining_d = count_q;
          state_d     = write_q ? StWdata : StRwait;
        end
      end
      StWdata: begin
        entry = {1'b0, wnib};
        if (!full) begin
          emit = 1'b1;
          pop  = grant_q;
          if (remaining_q == 4'd0) state_d     = StDone;
          else                     remaining_d = remaining_q - 4'd1;
        end
      end
      StRwait: begin
        if (i_bus_prog_addr == prog_addr_q) state_d = StRdata;
      end
      StRdata: begin
        if (i_bus_read_valid) begin
          rdata_d       = i_bus_nibble_in;
          rdata_valid_d = grant_q;
          if (remaining_q == 4'd0) state_d     = StDone;
          else                     remaining_d = remaining_q - 4'd1;
        end
      end
      StDone: begin
        done    = 1'b1;
        grant_d = 2'b00;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    prog_addr_d = emit ? prog_addr_q + 5'd1 : prog_addr_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= StIdle;
      grant_q       <= 2'b00;
      last_grant_q  <= 1'b1;
      write_q       <= 1'b0;
      addr_q        <= 20'h0;
      count_q       <= 4'h0;
      idx_q         <= 3'd0;
      remaining_q   <= 4'h0;
      prog_addr_q   <= 5'd0;
      rdata_q       <= 4'h0;
      rdata_valid_q <= 2'b00;
    end else if (i_clk_en) begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      remaining_q   <= remaining_d;
      prog_addr_q   <= prog_addr_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  // Pulses are masked on stalled and reset cycles so each lasts one enabled cycle.
  assign o_prog_we     = emit & adv;
  assign o_prog_waddr  = prog_addr_q;
  assign o_prog_wdata  = entry;
  assign o_prog_addr   = prog_addr_q;
  assign o_wdata_pop   = pop & {2{adv}};
  assign o_done        = grant_q & {2{done & adv}};
  assign o_rdata_valid = rdata_valid_q & {2{adv}};
  assign o_rdata       = rdata_q;
  assign o_grant       = grant_q;
  assign o_busy        = state_q != StIdle;

endmodule
